// File: rtl/mips_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage MIPS datapath and mips_hazard_ctrl.
//   Datapath -> controller: ID register fields, jump/branch/load indications,
//                           data-memory request/acknowledge.
//   Controller -> datapath: PC enable/select, per-stage enables and flushes,
//                           FSM state, stall counter, timeout error.
// Modport master is the controller side, slave is the datapath side.
interface mips_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_87;
    logic [4:0]       id_rt_87;
    logic             id_uses_rt_87;
    logic             id_jump_87;
    logic             ex_mem_read_87;
    logic [4:0]       ex_rt_87;
    logic             ex_branch_taken_87;
    logic             mem_req_87;
    logic             mem_ack_87;

    logic             pc_en_87;
    logic             pc_sel_87;
    logic             if_id_en_87;
    logic             if_id_flush_87;
    logic             id_ex_en_87;
    logic             id_ex_flush_87;
    logic             ex_mem_en_87;
    logic             mem_wb_en_87;
    logic [1:0]       state_87;
    logic [CNT_W-1:0] stall_cnt_87;
    logic             err_87;

    modport master (
        input  id_rs_87, id_rt_87, id_uses_rt_87, id_jump_87,
               ex_mem_read_87, ex_rt_87, ex_branch_taken_87,
               mem_req_87, mem_ack_87,
        output pc_en_87, pc_sel_87, if_id_en_87, if_id_flush_87,
               id_ex_en_87, id_ex_flush_87, ex_mem_en_87, mem_wb_en_87,
               state_87, stall_cnt_87, err_87
    );

    modport slave (
        output id_rs_87, id_rt_87, id_uses_rt_87, id_jump_87,
               ex_mem_read_87, ex_rt_87, ex_branch_taken_87,
               mem_req_87, mem_ack_87,
        input  pc_en_87, pc_sel_87, if_id_en_87, if_id_flush_87,
               id_ex_en_87, id_ex_flush_87, ex_mem_en_87, mem_wb_en_87,
               state_87, stall_cnt_87, err_87
    );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath.
// Drives PC enable/redirect select and the per-stage register enables and
// flushes from warm-up, load-use, branch/jump and data-memory wait sources.
// Also keeps a saturating count of PC-stall cycles and a sticky
// memory-timeout error flag.
// Ports:
//   clk_87  clock, rising edge
//   rst_87  asynchronous active-low reset
//   hz      hazard-control bundle (controller side, see mips_hazard_ctrl_if)
//
// state    | meaning
// WARM     | post-reset warm-up: pipeline flushed, PC held
// RUN      | normal issue, hazards resolved combinationally
// MEM_WAIT | data memory busy: whole pipeline frozen until ack
module mips_hazard_ctrl #(
    parameter int WARMUP      = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_87,
    input  logic                  rst_87,
    mips_hazard_ctrl_if.master    hz
);
    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        WARM     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WARM_W-1:0]  warm_cnt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [CNT_W-1:0]   stall_cnt;
    logic               err, err_nxt;
    logic               load_use;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = hz.ex_mem_read_87 && (hz.ex_rt_87 != 5'd0) &&
                      ((hz.ex_rt_87 == hz.id_rs_87) ||
                       (hz.id_uses_rt_87 && (hz.ex_rt_87 == hz.id_rt_87)));

    always_ff @(posedge clk_87 or negedge rst_87) begin
        if (!rst_87) begin
            state     <= WARM;
            warm_cnt  <= '0;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            err      <= err_nxt;
            if (state == WARM)
                warm_cnt <= warm_cnt + WARM_W'(1);
            if (!hz.pc_en_87 && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt         = state;
        wait_nxt          = wait_cnt;
        hz.pc_en_87       = 1'b0;
        hz.pc_sel_87      = 1'b0;
        hz.if_id_en_87    = 1'b0;
        hz.if_id_flush_87 = 1'b0;
        hz.id_ex_en_87    = 1'b0;
        hz.id_ex_flush_87 = 1'b0;
        hz.ex_mem_en_87   = 1'b0;
        hz.mem_wb_en_87   = 1'b0;
        case (state)
            WARM: begin
                hz.if_id_flush_87 = 1'b1;
                hz.id_ex_flush_87 = 1'b1;
                if (warm_cnt == WARM_W'(WARMUP - 1))
                    state_nxt = RUN;
            end
            RUN: begin
                if (hz.mem_req_87 && !hz.mem_ack_87) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else if (hz.ex_branch_taken_87) begin
                    // Squashes IF and ID, which also cancels any load-use stall.
                    hz.pc_en_87       = 1'b1;
                    hz.pc_sel_87      = 1'b1;
                    hz.if_id_en_87    = 1'b1;
                    hz.if_id_flush_87 = 1'b1;
                    hz.id_ex_en_87    = 1'b1;
                    hz.id_ex_flush_87 = 1'b1;
                    hz.ex_mem_en_87   = 1'b1;
                    hz.mem_wb_en_87   = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, insert a bubble into EX; a jump waits
                    // one cycle and is taken once the load has moved to MEM.
                    hz.id_ex_en_87    = 1'b1;
                    hz.id_ex_flush_87 = 1'b1;
                    hz.ex_mem_en_87   = 1'b1;
                    hz.mem_wb_en_87   = 1'b1;
                end else if (hz.id_jump_87) begin
                    hz.pc_en_87       = 1'b1;
                    hz.pc_sel_87      = 1'b1;
                    hz.if_id_en_87    = 1'b1;
                    hz.if_id_flush_87 = 1'b1;
                    hz.id_ex_en_87    = 1'b1;
                    hz.ex_mem_en_87   = 1'b1;
                    hz.mem_wb_en_87   = 1'b1;
                end else begin
                    hz.pc_en_87       = 1'b1;
                    hz.if_id_en_87    = 1'b1;
                    hz.id_ex_en_87    = 1'b1;
                    hz.ex_mem_en_87   = 1'b1;
                    hz.mem_wb_en_87   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ack_87) begin
                    hz.pc_en_87     = 1'b1;
                    hz.if_id_en_87  = 1'b1;
                    hz.id_ex_en_87  = 1'b1;
                    hz.ex_mem_en_87 = 1'b1;
                    hz.mem_wb_en_87 = 1'b1;
                    state_nxt       = RUN;
                    wait_nxt        = '0;
                end else if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = WARM;
        endcase
        err_nxt = err || ((state_nxt == MEM_WAIT) && (wait_nxt == WAIT_W'(MEM_TIMEOUT)));
    end

    assign hz.state_87     = state;
    assign hz.stall_cnt_87 = stall_cnt;
    assign hz.err_87       = err;
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl. Two instances share one stimulus:
// dut_a uses the default MEM_TIMEOUT, dut_b uses MEM_TIMEOUT = 4.
// Inputs change after the rising edge; outputs are sampled 1 ns later.
module tb_mips_hazard_ctrl;
    logic       clk_87 = 1'b0;
    logic       rst_87 = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, mem_req, mem_ack;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_87 = ~clk_87;

    mips_hazard_ctrl_if #(.CNT_W(16)) hz_a ();
    mips_hazard_ctrl_if #(.CNT_W(16)) hz_b ();

    assign hz_a.id_rs_87 = id_rs;              assign hz_b.id_rs_87 = id_rs;
    assign hz_a.id_rt_87 = id_rt;              assign hz_b.id_rt_87 = id_rt;
    assign hz_a.id_uses_rt_87 = id_uses_rt;    assign hz_b.id_uses_rt_87 = id_uses_rt;
    assign hz_a.id_jump_87 = id_jump;          assign hz_b.id_jump_87 = id_jump;
    assign hz_a.ex_mem_read_87 = ex_mem_read;  assign hz_b.ex_mem_read_87 = ex_mem_read;
    assign hz_a.ex_rt_87 = ex_rt;              assign hz_b.ex_rt_87 = ex_rt;
    assign hz_a.ex_branch_taken_87 = ex_branch_taken;
    assign hz_b.ex_branch_taken_87 = ex_branch_taken;
    assign hz_a.mem_req_87 = mem_req;          assign hz_b.mem_req_87 = mem_req;
    assign hz_a.mem_ack_87 = mem_ack;          assign hz_b.mem_ack_87 = mem_ack;

    mips_hazard_ctrl #(.WARMUP(3), .MEM_TIMEOUT(64), .CNT_W(16)) dut_a (
        .clk_87 (clk_87),
        .rst_87 (rst_87),
        .hz     (hz_a)
    );

    mips_hazard_ctrl #(.WARMUP(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut_b (
        .clk_87 (clk_87),
        .rst_87 (rst_87),
        .hz     (hz_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_jump = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_87);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Release reset after an edge and run through warm-up; leaves the
    // bench at the first RUN cycle with stall_cnt = 3.
    task automatic warm_up(input string tag);
        @(posedge clk_87);
        #1;
        rst_87 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk({tag, "_warm_state"}, 32'(hz_a.state_87), 32'd0);
            chk({tag, "_warm_pc_en"}, 32'(hz_a.pc_en_87), 32'd0);
            chk({tag, "_warm_flush"}, {30'd0, hz_a.if_id_flush_87, hz_a.id_ex_flush_87}, 32'd3);
            tick();
        end
        chk({tag, "_run_state"}, 32'(hz_a.state_87), 32'd1);
        chk({tag, "_run_pc_en"}, 32'(hz_a.pc_en_87), 32'd1);
        chk({tag, "_run_stall"}, 32'(hz_a.stall_cnt_87), 32'd3);
    endtask

    // {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    function automatic logic [31:0] ctl_a();
        return {24'd0, hz_a.pc_en_87, hz_a.pc_sel_87, hz_a.if_id_en_87, hz_a.if_id_flush_87,
                hz_a.id_ex_en_87, hz_a.id_ex_flush_87, hz_a.ex_mem_en_87, hz_a.mem_wb_en_87};
    endfunction

    initial begin
        idle();
        #3;
        chk("rst_state", 32'(hz_a.state_87), 32'd0);
        chk("rst_ctl", ctl_a(), 32'b0001_0100);
        chk("rst_stall", 32'(hz_a.stall_cnt_87), 32'd0);
        chk("rst_err", 32'(hz_a.err_87), 32'd0);

        warm_up("w1");
        chk("run_idle_ctl", ctl_a(), 32'b1010_1011);

        // Load-use on rs.
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        settle();
        chk("lu_rs_ctl", ctl_a(), 32'b0000_1111);
        tick();
        chk("lu_rs_stall", 32'(hz_a.stall_cnt_87), 32'd4);
        idle();
        settle();
        chk("lu_rs_clear", ctl_a(), 32'b1010_1011);
        tick();

        // Load to register 0 never stalls.
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        settle();
        chk("lu_r0_ctl", ctl_a(), 32'b1010_1011);
        tick();

        // rt match ignored unless rt is a source.
        idle();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        settle();
        chk("lu_rt_unused", ctl_a(), 32'b1010_1011);
        id_uses_rt = 1'b1;
        settle();
        chk("lu_rt_used", ctl_a(), 32'b0000_1111);
        tick();
        chk("lu_rt_stall", 32'(hz_a.stall_cnt_87), 32'd5);

        // Taken branch overrides load-use.
        ex_branch_taken = 1'b1;
        settle();
        chk("br_lu_ctl", ctl_a(), 32'b1111_1111);
        tick();
        chk("br_lu_stall", 32'(hz_a.stall_cnt_87), 32'd5);

        // Jump during load-use is deferred one cycle.
        idle();
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_jump = 1'b1;
        settle();
        chk("jmp_lu_c1", ctl_a(), 32'b0000_1111);
        tick();
        ex_mem_read = 1'b0;
        settle();
        chk("jmp_lu_c2", ctl_a(), 32'b1111_1011);
        tick();
        chk("jmp_lu_stall", 32'(hz_a.stall_cnt_87), 32'd6);

        // Five-cycle memory wait; branch/jump ignored while waiting.
        idle();
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            id_jump = (i == 2);
            ex_branch_taken = (i == 3);
            settle();
            chk($sformatf("mw_freeze%0d", i), ctl_a(), 32'd0);
            tick();
            chk($sformatf("mw_state%0d", i), 32'(hz_a.state_87), 32'd2);
        end
        id_jump = 1'b0; ex_branch_taken = 1'b0; mem_ack = 1'b1;
        settle();
        chk("mw_ack_ctl", ctl_a(), 32'b1010_1011);
        tick();
        chk("mw_ack_state", 32'(hz_a.state_87), 32'd1);
        chk("mw_stall", 32'(hz_a.stall_cnt_87), 32'd11);
        chk("mw_err", 32'(hz_a.err_87), 32'd0);

        // Timeout on dut_b (MEM_TIMEOUT = 4) after a fresh reset.
        idle();
        rst_87 = 1'b0;
        settle();
        warm_up("w2");
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("to_err_b_3", 32'(hz_b.err_87), 32'd0);
        tick();
        chk("to_err_b_4", 32'(hz_b.err_87), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("to_err_b_hold", 32'(hz_b.err_87), 32'd1);
        chk("to_state_b", 32'(hz_b.state_87), 32'd2);
        chk("to_err_a", 32'(hz_a.err_87), 32'd0);
        chk("to_stall_b", 32'(hz_b.stall_cnt_87), 32'd11);

        // Asynchronous reset mid-wait, checked before any clock edge.
        #2;
        rst_87 = 1'b0;
        #1;
        chk("arst_state", 32'(hz_b.state_87), 32'd0);
        chk("arst_err", 32'(hz_b.err_87), 32'd0);
        chk("arst_stall", 32'(hz_b.stall_cnt_87), 32'd0);
        chk("arst_ctl", ctl_a(), 32'b0001_0100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
